cp0_exc_unit: RTL and testbench
===============================

Name: cp0_exc_unit

Overview:
- Coprocessor 0 in the MEM stage. It is the final consumer of the per-stage exception-code pipeline registers (D→E→M).
- Each cycle it merges the M-stage exception code with pending hardware interrupts and decides whether the trap is taken.
- On a taken trap it updates SR, Cause and EPC, and drives the pipeline-wide flush pair: ActivateCP0 for trap entry, CoolCP0 for eret.
- It also services mfc0/mtc0.

Parameters:
- PRID_VAL, 32'h0000_4255, read-only value of PRId (reg 15).
- HANDLER_ADDR, 32'h0000_4180, exception handler entry address, output on Handler_Addr.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Rst  in  1  synchronous, active-high reset.
- ExcCode_M  in  5  exception code of the M-stage instruction. 0 = none. Codes: 4 AdEL, 5 AdES, 10 RI, 12 Ov.
- PC_M  in  32  PC of the M-stage instruction.
- BD_M  in  1  M-stage instruction is in a branch delay slot.
- Valid_M  in  1  M stage holds a real instruction, not a bubble.
- Eret_M  in  1  M-stage instruction is eret.
- HWInt  in  6  external interrupt lines, level-sensitive.
- CP0_We  in  1  mtc0 write enable.
- CP0_Addr  in  5  mfc0/mtc0 register number.
- CP0_WData  in  32  mtc0 data.
- CP0_RData  out  32  mfc0 read data, combinational.
- EPC_Out  out  32  current EPC, the eret target.
- Handler_Addr  out  32  equals HANDLER_ADDR.
- ActivateCP0  out  1  trap taken this cycle, combinational. Flushes all pipeline registers and redirects the PC.
- CoolCP0  out  1  eret committing this cycle, combinational. Flushes F/D/E and redirects the PC to EPC_Out.

Behaviour:
- Reset state:
  - SR = 0, i.e. IM = 0, EXL = 0, IE = 0.
  - Cause = 0.
  - EPC = 0.
  - ActivateCP0 = 0 and CoolCP0 = 0 while Rst is high, regardless of other inputs.
- Register fields:
  - SR (12): IM = [15:10], EXL = [1], IE = [0]. All other bits read 0.
  - Cause (13): BD = [31], IP = [15:10], ExcCode = [6:2]. All other bits read 0.
  - EPC (14): bits [31:2] are writable; [1:0] read 0.
  - PRId (15): reads PRID_VAL.
  - Any other address reads 0, and writes to it are ignored.
- Cause.IP is loaded from HWInt every non-reset cycle, whatever else happens.
- Interrupt request: IntReq = |(HWInt & IM) & IE & ~EXL & Valid_M.
  - A bubble in M defers the interrupt to the next valid instruction.
- Exception request: ExcReq = (ExcCode_M != 0) & ~EXL & Valid_M.
- ActivateCP0 = IntReq | ExcReq. Interrupt has priority over a synchronous exception.
- On the posedge with ActivateCP0 = 1:
  - EXL <= 1.
  - Cause.BD <= BD_M.
  - Cause.ExcCode <= 0 if IntReq, else ExcCode_M.
  - EPC <= BD_M ? PC_M - 4 : PC_M, with bits [1:0] forced to 0.
- CoolCP0 = Eret_M & Valid_M & ~ActivateCP0. On that posedge, EXL <= 0.
- mtc0 commits on the posedge only if CP0_We & ~ActivateCP0, so a trap suppresses the write.
  - When eret and mtc0 coincide (not producible by legal code), the eret's EXL clear wins over an mtc0 write to the EXL bit.
- mfc0 reads pre-edge values. There is no internal write-to-read bypass; the M/W forwarding path handles that.
- The mtc0 value is visible to IntReq from the next cycle onward.
- While EXL = 1, both further exceptions and interrupts are ignored: no nesting.
- Rst asserted mid-trap: all registers return to their reset values on that edge, and ActivateCP0/CoolCP0 are held at 0.

Optional Feature:
- Macro: CP0_COUNT_EN.
- When defined, Count (reg 9) and Compare (reg 11) are implemented:
  - Count increments every cycle and wraps from 32'hFFFF_FFFF to 0.
  - A mtc0 write to Count replaces that cycle's increment.
  - The timer interrupt bit is set on the edge where Count == Compare.
  - The timer interrupt clears on a mtc0 write to Compare.
  - The timer interrupt ORs into HWInt[5] before the IP latch and the IntReq computation.
- When not defined, regs 9 and 11 read 0, writes to them are ignored, and HWInt[5] passes through unchanged.

Test Plan:
- Reset with Rst = 1 and ExcCode_M = 12 → ActivateCP0 = 0. Reads of regs 12, 13 and 14 return 0; reg 15 returns 32'h0000_4255.
- SR = 32'h0000_0401; HWInt = 6'b000001 at PC_M = 32'h3008, BD_M = 0 → ActivateCP0 = 1 that cycle. Next cycle: EPC = 32'h3008, ExcCode = 0, EXL = 1, IP[10] = 1.
- ExcCode_M = 12 at PC_M = 32'h3010, BD_M = 1, with HWInt[0] also pending and unmasked → interrupt wins: ExcCode = 0, EPC = 32'h300C, BD = 1.
- EXL = 1, ExcCode_M = 4 → ActivateCP0 = 0 and no register change. Then Eret_M = 1 → CoolCP0 = 1, EPC_Out = saved EPC, and EXL = 0 next cycle.
- mtc0 to EPC (32'h0000_3abc) coinciding with ExcCode_M = 10 at PC_M = 32'h3020 → the write is dropped; EPC = 32'h3020 and ExcCode = 10.
- With CP0_COUNT_EN defined: Compare = 5, IM[15] = 1, IE = 1 → ActivateCP0 asserts shortly after Count reaches 5 (as soon as Valid_M is high). Writing Compare then clears IP[15].

Source files
------------

// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: MEM-stage coprocessor 0 that takes traps, handles eret and services mfc0/mtc0.
// Ports: Clk/Rst (sync, active-high) clock and reset; ExcCode_M, PC_M, BD_M, Valid_M, Eret_M
// describe the M-stage instruction; HWInt are level interrupt lines; CP0_We/CP0_Addr/CP0_WData
// are the mtc0 write port; CP0_RData is the combinational mfc0 read; EPC_Out is the eret target;
// Handler_Addr is the trap entry; ActivateCP0 flags trap entry, CoolCP0 flags eret commit.
// Optional: define CP0_COUNT_EN to add Count (reg 9) and Compare (reg 11) with a timer
// interrupt on HWInt[5]. Cause is read-only to software; only hardware updates its fields.
module cp0_exc_unit #(
  parameter logic [31:0] PRID_VAL = 32'h0000_4255,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  ExcCode_M,
  input  logic [31:0] PC_M,
  input  logic        BD_M,
  input  logic        Valid_M,
  input  logic        Eret_M,
  input  logic [5:0]  HWInt,
  input  logic        CP0_We,
  input  logic [4:0]  CP0_Addr,
  input  logic [31:0] CP0_WData,
  output logic [31:0] CP0_RData,
  output logic [31:0] EPC_Out,
  output logic [31:0] Handler_Addr,
  output logic        ActivateCP0,
  output logic        CoolCP0
);
  logic [5:0]  im, ip, hw;
  logic        exl, ie, bd;
  logic [4:0]  exc;
  logic [31:0] epc, epc_trap, sr_val, cause_val, ext_rd;
  logic        int_req, exc_req, wr;
`ifdef CP0_COUNT_EN
  logic [31:0] count, compare;
  logic        ti;
  assign hw = HWInt | {ti, 5'b0};
  assign ext_rd = CP0_Addr == 5'd9 ? count : CP0_Addr == 5'd11 ? compare : 32'd0;
  always_ff @(posedge Clk) begin
    if (Rst) begin
      count <= 32'd0;
      compare <= 32'd0;
      ti <= 1'b0;
    end else begin
      count <= (wr && CP0_Addr == 5'd9) ? CP0_WData : count + 32'd1;
      if (wr && CP0_Addr == 5'd11) begin
        compare <= CP0_WData;
        ti <= 1'b0;
      end else if (count == compare) ti <= 1'b1;
    end
  end
`else
  assign hw = HWInt;
  assign ext_rd = 32'd0;
`endif
  assign int_req = |(hw & im) & ie & ~exl & Valid_M;
  assign exc_req = (ExcCode_M != 5'd0) & ~exl & Valid_M;
  assign ActivateCP0 = ~Rst & (int_req | exc_req);
  assign CoolCP0 = ~Rst & Eret_M & Valid_M & ~ActivateCP0;
  // a trap entering this cycle swallows any coincident mtc0
  assign wr = CP0_We & ~ActivateCP0;
  assign epc_trap = (BD_M ? PC_M - 32'd4 : PC_M) & ~32'd3;
  assign sr_val = {16'd0, im, 8'd0, exl, ie};
  assign cause_val = {bd, 15'd0, ip, 3'd0, exc, 2'd0};
  assign EPC_Out = epc;
  assign Handler_Addr = HANDLER_ADDR;
  always_comb begin
    CP0_RData = CP0_Addr == 5'd12 ? sr_val :
                CP0_Addr == 5'd13 ? cause_val :
                CP0_Addr == 5'd14 ? epc :
                CP0_Addr == 5'd15 ? PRID_VAL : ext_rd;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      im <= 6'd0;
      exl <= 1'b0;
      ie <= 1'b0;
      bd <= 1'b0;
      ip <= 6'd0;
      exc <= 5'd0;
      epc <= 32'd0;
    end else begin
      ip <= hw;
      if (ActivateCP0) begin
        exl <= 1'b1;
        bd <= BD_M;
        exc <= int_req ? 5'd0 : ExcCode_M;
        epc <= epc_trap;
      end else begin
        if (wr && CP0_Addr == 5'd12) begin
          im <= CP0_WData[15:10];
          ie <= CP0_WData[0];
        end
        // eret's EXL clear outranks a same-cycle mtc0 to SR
        if (CoolCP0) exl <= 1'b0;
        else if (wr && CP0_Addr == 5'd12) exl <= CP0_WData[1];
        if (wr && CP0_Addr == 5'd14) epc <= CP0_WData & ~32'd3;
      end
    end
  end
endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb_cp0_exc_unit: directed and randomized checks of cp0_exc_unit against a word-level model.
module tb_cp0_exc_unit;
  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [4:0]  ExcCode_M = 5'd0;
  logic [31:0] PC_M = 32'd0;
  logic        BD_M = 1'b0;
  logic        Valid_M = 1'b0;
  logic        Eret_M = 1'b0;
  logic [5:0]  HWInt = 6'd0;
  logic        CP0_We = 1'b0;
  logic [4:0]  CP0_Addr = 5'd0;
  logic [31:0] CP0_WData = 32'd0;
  logic [31:0] CP0_RData, EPC_Out, Handler_Addr;
  logic        ActivateCP0, CoolCP0;
  int tests = 0;
  int fails = 0;
  logic [31:0] m_sr, m_cause, m_epc;
  cp0_exc_unit dut (
    .Clk(Clk), .Rst(Rst), .ExcCode_M(ExcCode_M), .PC_M(PC_M), .BD_M(BD_M),
    .Valid_M(Valid_M), .Eret_M(Eret_M), .HWInt(HWInt), .CP0_We(CP0_We),
    .CP0_Addr(CP0_Addr), .CP0_WData(CP0_WData), .CP0_RData(CP0_RData),
    .EPC_Out(EPC_Out), .Handler_Addr(Handler_Addr), .ActivateCP0(ActivateCP0),
    .CoolCP0(CoolCP0)
  );
  always #5 Clk = ~Clk;
  function automatic bit m_int();
    return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1] && Valid_M;
  endfunction
  function automatic bit m_act();
    return !Rst && (m_int() || (ExcCode_M != 5'd0 && !m_sr[1] && Valid_M));
  endfunction
  function automatic bit m_cool();
    return !Rst && Eret_M && Valid_M && !m_act();
  endfunction
  function automatic logic [31:0] m_rd(input logic [4:0] a);
    case (a)
      5'd12: return m_sr;
      5'd13: return m_cause;
      5'd14: return m_epc;
      5'd15: return 32'h0000_4255;
      default: return 32'd0;
    endcase
  endfunction
  task automatic tick();
    bit act, intr, cool;
    act = m_act();
    intr = m_int();
    cool = m_cool();
    if (Rst) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else begin
      m_cause = (m_cause & ~32'h0000_FC00) | (32'(HWInt) << 10);
      if (act) begin
        m_sr = m_sr | 32'h2;
        m_cause = (m_cause & 32'h0000_FC00) | (32'(BD_M) << 31) | (intr ? 32'd0 : 32'(ExcCode_M) << 2);
        m_epc = (BD_M ? PC_M - 4 : PC_M) & 32'hFFFF_FFFC;
      end else if (CP0_We) begin
        if (CP0_Addr == 12) m_sr = CP0_WData & 32'h0000_FC03;
        if (CP0_Addr == 14) m_epc = CP0_WData & 32'hFFFF_FFFC;
      end
      if (cool) m_sr = m_sr & ~32'h2;
    end
    @(posedge Clk);
    #1;
  endtask
  task automatic idle();
    Rst = 0; ExcCode_M = 0; BD_M = 0; Valid_M = 0; Eret_M = 0; HWInt = 0; CP0_We = 0;
  endtask
  task automatic test_reset();
    Rst = 1; ExcCode_M = 12; Valid_M = 1; HWInt = 6'h3F;
    tick();
    #2;
    tests++;
    if (ActivateCP0 !== 1'b0) begin fails++; $display("FAIL reset_act got=%b exp=0", ActivateCP0); end
    for (int a = 12; a <= 15; a++) begin
      CP0_Addr = 5'(a);
      #1;
      tests++;
      if (CP0_RData !== (a == 15 ? 32'h0000_4255 : 32'd0)) begin
        fails++; $display("FAIL reset_reg%0d got=%h exp=%h", a, CP0_RData, m_rd(5'(a)));
      end
    end
    tests++;
    if (Handler_Addr !== 32'h0000_4180) begin fails++; $display("FAIL handler got=%h exp=00004180", Handler_Addr); end
    idle();
    tick();
  endtask
  task automatic test_interrupt();
    CP0_We = 1; CP0_Addr = 12; CP0_WData = 32'h0000_0401; Valid_M = 1;
    tick();
    CP0_We = 0; HWInt = 6'b000001; PC_M = 32'h3008; BD_M = 0;
    #2;
    tests++;
    if (ActivateCP0 !== 1'b1) begin fails++; $display("FAIL int_act got=%b exp=1", ActivateCP0); end
    tick();
    Valid_M = 0;
    CP0_Addr = 14; #1;
    tests++;
    if (CP0_RData !== 32'h3008) begin fails++; $display("FAIL int_epc got=%h exp=00003008", CP0_RData); end
    CP0_Addr = 13; #1;
    tests++;
    if (CP0_RData !== 32'h0000_0400 || CP0_RData !== m_cause) begin
      fails++; $display("FAIL int_cause got=%h exp=00000400", CP0_RData);
    end
    CP0_Addr = 12; #1;
    tests++;
    if (CP0_RData !== 32'h0000_0403) begin fails++; $display("FAIL int_sr got=%h exp=00000403", CP0_RData); end
  endtask
  task automatic test_eret();
    HWInt = 0; Valid_M = 1; Eret_M = 1; #2;
    tests++;
    if (CoolCP0 !== 1'b1 || EPC_Out !== m_epc) begin
      fails++; $display("FAIL eret cool=%b epc=%h exp cool=1 epc=%h", CoolCP0, EPC_Out, m_epc);
    end
    tick();
    Eret_M = 0; CP0_Addr = 12; #1;
    tests++;
    if (CP0_RData !== m_sr || CP0_RData[1] !== 1'b0) begin fails++; $display("FAIL eret_exl got=%h exp=%h", CP0_RData, m_sr); end
  endtask
  task automatic test_priority();
    ExcCode_M = 12; PC_M = 32'h3010; BD_M = 1; HWInt = 6'b000001; Valid_M = 1; #2;
    tests++;
    if (ActivateCP0 !== 1'b1) begin fails++; $display("FAIL prio_act got=%b exp=1", ActivateCP0); end
    tick();
    ExcCode_M = 0; CP0_Addr = 13; #1;
    tests++;
    if (CP0_RData !== 32'h8000_0400) begin fails++; $display("FAIL prio_cause got=%h exp=80000400", CP0_RData); end
    tests++;
    if (EPC_Out !== 32'h300C) begin fails++; $display("FAIL prio_epc got=%h exp=0000300c", EPC_Out); end
  endtask
  task automatic test_no_nesting();
    ExcCode_M = 4; HWInt = 6'h3F; PC_M = 32'h5000; BD_M = 0; Valid_M = 1; #2;
    tests++;
    if (ActivateCP0 !== 1'b0) begin fails++; $display("FAIL nest_act got=%b exp=0", ActivateCP0); end
    tick();
    tests++;
    if (EPC_Out !== 32'h300C) begin fails++; $display("FAIL nest_epc got=%h exp=0000300c", EPC_Out); end
    ExcCode_M = 0;
    test_eret();
  endtask
  task automatic test_mtc0_drop();
    HWInt = 0; CP0_We = 1; CP0_Addr = 14; CP0_WData = 32'h0000_3abc;
    ExcCode_M = 10; PC_M = 32'h3020; BD_M = 0; Valid_M = 1; #2;
    tests++;
    if (ActivateCP0 !== 1'b1) begin fails++; $display("FAIL drop_act got=%b exp=1", ActivateCP0); end
    tick();
    CP0_We = 0; ExcCode_M = 0;
    tests++;
    if (EPC_Out !== 32'h3020) begin fails++; $display("FAIL drop_epc got=%h exp=00003020", EPC_Out); end
    CP0_Addr = 13; #1;
    tests++;
    if (CP0_RData[6:2] !== 5'd10) begin fails++; $display("FAIL drop_exc got=%0d exp=10", CP0_RData[6:2]); end
    test_eret();
  endtask
  task automatic test_bubble();
    HWInt = 6'b000001; Valid_M = 0; #2;
    tests++;
    if (ActivateCP0 !== 1'b0) begin fails++; $display("FAIL bubble_act got=%b exp=0", ActivateCP0); end
    tick();
    Valid_M = 1; PC_M = 32'h4000; #2;
    tests++;
    if (ActivateCP0 !== 1'b1) begin fails++; $display("FAIL bubble_next got=%b exp=1", ActivateCP0); end
  endtask
  task automatic test_reset_mid_trap();
    tick();
    Rst = 1; ExcCode_M = 5; Eret_M = 1; #2;
    tests++;
    if (ActivateCP0 !== 1'b0 || CoolCP0 !== 1'b0) begin
      fails++; $display("FAIL rst_mid act=%b cool=%b exp 0 0", ActivateCP0, CoolCP0);
    end
    tick();
    idle();
    CP0_Addr = 12; #1;
    tests++;
    if (CP0_RData !== 32'd0 || EPC_Out !== 32'd0) begin
      fails++; $display("FAIL rst_mid_regs sr=%h epc=%h exp 0 0", CP0_RData, EPC_Out);
    end
  endtask
  task automatic test_random();
    logic [4:0] codes [5] = '{5'd0, 5'd4, 5'd5, 5'd10, 5'd12};
    logic [4:0] addrs [7] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
    for (int i = 0; i < 400; i++) begin
      Rst = ($urandom_range(0, 49) == 0);
      ExcCode_M = ($urandom_range(0, 3) == 0) ? codes[$urandom_range(1, 4)] : 5'd0;
      PC_M = $urandom;
      BD_M = 1'($urandom);
      Valid_M = ($urandom_range(0, 4) != 0);
      Eret_M = ($urandom_range(0, 5) == 0);
      HWInt = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      CP0_We = ($urandom_range(0, 2) == 0);
      CP0_Addr = addrs[$urandom_range(0, 6)];
      CP0_WData = $urandom;
      #2;
      tests++;
      if (ActivateCP0 !== m_act() || CoolCP0 !== m_cool()) begin
        fails++; $display("FAIL rand%0d_flush act=%b cool=%b exp %b %b", i, ActivateCP0, CoolCP0, m_act(), m_cool());
      end
      tests++;
      if (CP0_RData !== m_rd(CP0_Addr) || EPC_Out !== m_epc) begin
        fails++; $display("FAIL rand%0d_regs rd=%h epc=%h exp %h %h", i, CP0_RData, EPC_Out, m_rd(CP0_Addr), m_epc);
      end
      tick();
    end
  endtask
  initial begin
    test_reset();
    test_interrupt();
    test_eret();
    test_priority();
    test_no_nesting();
    test_mtc0_drop();
    test_bubble();
    test_reset_mid_trap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
